// File: rtl/product_accumulator.sv
// Accumulates a frame of signed products from the sequential multiplier and
// presents the full-precision frame sum over a valid/ready output handshake.
//
// Ports:
//   clk, reset (async, active-low)
//   product_in, last_src, valid_src, ready_src : term input handshake
//   sum_out, term_count, valid_dst, ready_dst  : frame sum output handshake
module product_accumulator #(
  parameter int NUMBITS  = 16,
  parameter int NUMTERMS = 4,
  localparam int ACCBITS = 2*NUMBITS + $clog2(NUMTERMS),
  localparam int CNTBITS = $clog2(NUMTERMS+1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic signed [2*NUMBITS-1:0] product_in,
  input  logic                      last_src,
  input  logic                      valid_src,
  output logic                      ready_src,
  output logic signed [ACCBITS-1:0] sum_out,
  output logic [CNTBITS-1:0]        term_count,
  output logic                      valid_dst,
  input  logic                      ready_dst
);

  localparam int GUARD = ACCBITS - 2*NUMBITS;
  localparam logic [CNTBITS-1:0] MAXCNT = CNTBITS'(NUMTERMS);

  typedef enum logic {
    ACCUM,
    HOLD
  } state_t;

  state_t state, state_nxt;

  logic signed [ACCBITS-1:0] acc, acc_nxt;
  logic signed [ACCBITS-1:0] sum_nxt;
  logic signed [ACCBITS-1:0] term_ext;
  logic [CNTBITS-1:0]        count, count_nxt;
  logic [CNTBITS-1:0]        count_inc;
  logic [CNTBITS-1:0]        tc_nxt;
  logic                      accept;

  // Handshake flags come straight from the state register, so neither
  // valid_src nor ready_dst reaches the opposite side combinationally.
  assign ready_src = (state == ACCUM);
  assign valid_dst = (state == HOLD);
  assign accept    = valid_src & ready_src;

  assign term_ext  = {{GUARD{product_in[2*NUMBITS-1]}}, product_in};
  assign count_inc = count + CNTBITS'(1);

  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    count_nxt = count;
    sum_nxt   = sum_out;
    tc_nxt    = term_count;
    unique case (state)
      ACCUM: begin
        if (accept) begin
          acc_nxt   = acc + term_ext;
          count_nxt = count_inc;
          // The closing term lands directly in the output registers so
          // the sum is presented the cycle after its accept edge.
          if (last_src || count_inc == MAXCNT) begin
            sum_nxt   = acc_nxt;
            tc_nxt    = count_inc;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (ready_dst) begin
          state_nxt = ACCUM;
          acc_nxt   = '0;
          count_nxt = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ACCUM;
      acc        <= '0;
      count      <= '0;
      sum_out    <= '0;
      term_count <= '0;
    end else begin
      state      <= state_nxt;
      acc        <= acc_nxt;
      count      <= count_nxt;
      sum_out    <= sum_nxt;
      term_count <= tc_nxt;
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Scoreboard bench for product_accumulator: expected frame sums are queued
// as terms are driven and popped when the block presents a result.
module tb_product_accumulator;

  localparam int NB = 16;
  localparam int NT = 4;
  localparam int AB = 2*NB + $clog2(NT);
  localparam int CB = $clog2(NT+1);

  logic          clk = 1'b0;
  logic          reset;
  logic [2*NB-1:0] product_in;
  logic          last_src;
  logic          valid_src;
  logic          ready_src;
  logic [AB-1:0] sum_out;
  logic [CB-1:0] term_count;
  logic          valid_dst;
  logic          ready_dst;

  product_accumulator #(.NUMBITS(NB), .NUMTERMS(NT)) dut (
    .clk        (clk),
    .reset      (reset),
    .product_in (product_in),
    .last_src   (last_src),
    .valid_src  (valid_src),
    .ready_src  (ready_src),
    .sum_out    (sum_out),
    .term_count (term_count),
    .valid_dst  (valid_dst),
    .ready_dst  (ready_dst)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AB-1:0] sum;
    logic [CB-1:0] cnt;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   tests = 0;
  int   fails = 0;
  bit   ok;

  function automatic exp_t mk(input longint s, input int c);
    exp_t r;
    r.sum = AB'(s);
    r.cnt = CB'(c);
    return r;
  endfunction

  // Present one term and return just after the edge that accepts it.
  task automatic send(input logic [2*NB-1:0] p, input logic l);
    @(negedge clk);
    product_in = p;
    last_src   = l;
    valid_src  = 1'b1;
    for (int i = 0; i < 50 && !ready_src; i++) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid_src = 1'b0;
    last_src  = 1'b0;
  endtask

  task automatic wait_valid(output bit got);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (valid_dst) begin
        got = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    product_in = '0;
    last_src = 1'b0;
    valid_src = 1'b0;
    ready_dst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({ready_src, valid_dst, sum_out, term_count} !==
        {1'b1, 1'b0, {AB{1'b0}}, {CB{1'b0}}}) begin
      fails++;
      $display("FAIL reset_state: rdy=%0b vld=%0b sum=%0h cnt=%0d",
               ready_src, valid_dst, sum_out, term_count);
    end
    reset = 1'b1;
  endtask

  task automatic test_basic();
    ready_dst = 1'b1;
    send(32'd6, 1'b0);
    send(-32'sd15, 1'b0);
    send(32'd100, 1'b0);
    send(-32'sd1, 1'b0);
    idle();
    q.push_back(mk(90, 4));
    @(negedge clk);
    e = q.pop_front();
    tests++;
    if (valid_dst !== 1'b1 || ready_src !== 1'b0 ||
        sum_out !== e.sum || term_count !== e.cnt) begin
      fails++;
      $display("FAIL basic_latency: vld=%0b rdy=%0b sum=%0h cnt=%0d, want 1 0 %0h %0d",
               valid_dst, ready_src, sum_out, term_count, e.sum, e.cnt);
    end
    @(negedge clk);
    tests++;
    if (valid_dst !== 1'b0 || ready_src !== 1'b1 || sum_out !== e.sum) begin
      fails++;
      $display("FAIL basic_release: vld=%0b rdy=%0b sum=%0h, want 0 1 %0h",
               valid_dst, ready_src, sum_out, e.sum);
    end
  endtask

  task automatic test_extremes();
    ready_dst = 1'b1;
    repeat (4) send(32'h4000_0000, 1'b0);
    idle();
    q.push_back(mk(64'h1_0000_0000, 4));
    wait_valid(ok);
    e = q.pop_front();
    tests++;
    if (!ok || sum_out !== e.sum || term_count !== e.cnt) begin
      fails++;
      $display("FAIL max_pos: vld=%0b sum=%0h cnt=%0d, want %0h %0d",
               ok, sum_out, term_count, e.sum, e.cnt);
    end
    repeat (4) send(32'hC000_8000, 1'b0);
    idle();
    q.push_back(mk(-64'sd4294836224, 4));
    wait_valid(ok);
    e = q.pop_front();
    tests++;
    if (!ok || sum_out !== e.sum || term_count !== e.cnt) begin
      fails++;
      $display("FAIL max_neg: vld=%0b sum=%0h cnt=%0d, want %0h %0d",
               ok, sum_out, term_count, e.sum, e.cnt);
    end
  endtask

  task automatic test_last();
    ready_dst = 1'b1;
    send(32'd7, 1'b0);
    send(32'd3, 1'b1);
    idle();
    q.push_back(mk(10, 2));
    wait_valid(ok);
    e = q.pop_front();
    tests++;
    if (!ok || sum_out !== e.sum || term_count !== e.cnt) begin
      fails++;
      $display("FAIL early_last: vld=%0b sum=%0h cnt=%0d, want %0h %0d",
               ok, sum_out, term_count, e.sum, e.cnt);
    end
    repeat (4) send(32'd1, 1'b0);
    idle();
    q.push_back(mk(4, 4));
    wait_valid(ok);
    e = q.pop_front();
    tests++;
    if (!ok || sum_out !== e.sum || term_count !== e.cnt) begin
      fails++;
      $display("FAIL no_residue: vld=%0b sum=%0h cnt=%0d, want %0h %0d",
               ok, sum_out, term_count, e.sum, e.cnt);
    end
    send(32'd9, 1'b1);
    idle();
    q.push_back(mk(9, 1));
    wait_valid(ok);
    e = q.pop_front();
    tests++;
    if (!ok || sum_out !== e.sum || term_count !== e.cnt) begin
      fails++;
      $display("FAIL one_term: vld=%0b sum=%0h cnt=%0d, want %0h %0d",
               ok, sum_out, term_count, e.sum, e.cnt);
    end
    send(32'd2, 1'b0);
    send(32'd2, 1'b0);
    send(32'd2, 1'b0);
    send(32'd2, 1'b1);
    idle();
    q.push_back(mk(8, 4));
    wait_valid(ok);
    e = q.pop_front();
    tests++;
    if (!ok || sum_out !== e.sum || term_count !== e.cnt) begin
      fails++;
      $display("FAIL last_on_full: vld=%0b sum=%0h cnt=%0d, want %0h %0d",
               ok, sum_out, term_count, e.sum, e.cnt);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (valid_dst !== 1'b0) begin
      fails++;
      $display("FAIL last_on_full_once: vld=%0b, want 0", valid_dst);
    end
  endtask

  task automatic test_backpressure();
    ready_dst = 1'b0;
    send(32'd6, 1'b0);
    send(-32'sd15, 1'b0);
    send(32'd100, 1'b0);
    send(-32'sd1, 1'b0);
    product_in = 32'd55;
    last_src = 1'b0;
    q.push_back(mk(90, 4));
    e = q.pop_front();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests++;
      if (valid_dst !== 1'b1 || ready_src !== 1'b0 ||
          sum_out !== e.sum || term_count !== e.cnt) begin
        fails++;
        $display("FAIL hold_stall%0d: vld=%0b rdy=%0b sum=%0h cnt=%0d, want 1 0 %0h %0d",
                 i, valid_dst, ready_src, sum_out, term_count, e.sum, e.cnt);
      end
    end
    ready_dst = 1'b1;
    send(32'd55, 1'b0);
    send(32'd1, 1'b1);
    idle();
    q.push_back(mk(56, 2));
    wait_valid(ok);
    e = q.pop_front();
    tests++;
    if (!ok || sum_out !== e.sum || term_count !== e.cnt) begin
      fails++;
      $display("FAIL held_term: vld=%0b sum=%0h cnt=%0d, want %0h %0d",
               ok, sum_out, term_count, e.sum, e.cnt);
    end
  endtask

  task automatic test_gaps();
    int early;
    early = 0;
    ready_dst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      send(32'd2, 1'b0);
      idle();
      if (k < 3) begin
        repeat (2) begin
          @(negedge clk);
          if (valid_dst) early++;
        end
      end
    end
    tests++;
    if (early !== 0) begin
      fails++;
      $display("FAIL gap_idle: early valid cycles=%0d, want 0", early);
    end
    q.push_back(mk(8, 4));
    wait_valid(ok);
    e = q.pop_front();
    tests++;
    if (!ok || sum_out !== e.sum || term_count !== e.cnt) begin
      fails++;
      $display("FAIL gap_sum: vld=%0b sum=%0h cnt=%0d, want %0h %0d",
               ok, sum_out, term_count, e.sum, e.cnt);
    end
  endtask

  task automatic test_midreset();
    ready_dst = 1'b1;
    send(32'd1, 1'b0);
    send(32'd1, 1'b0);
    idle();
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests++;
    if ({ready_src, valid_dst, sum_out, term_count} !==
        {1'b1, 1'b0, {AB{1'b0}}, {CB{1'b0}}}) begin
      fails++;
      $display("FAIL midframe_reset: rdy=%0b vld=%0b sum=%0h cnt=%0d",
               ready_src, valid_dst, sum_out, term_count);
    end
    @(negedge clk);
    reset = 1'b1;
    ready_dst = 1'b0;
    repeat (4) send(32'd5, 1'b0);
    idle();
    wait_valid(ok);
    reset = 1'b0;
    #1;
    tests++;
    if (valid_dst !== 1'b0 || ready_src !== 1'b1) begin
      fails++;
      $display("FAIL hold_reset: vld=%0b rdy=%0b, want 0 1",
               valid_dst, ready_src);
    end
    @(negedge clk);
    reset = 1'b1;
    ready_dst = 1'b1;
    send(32'd1, 1'b0);
    send(32'd2, 1'b0);
    send(32'd3, 1'b0);
    send(32'd4, 1'b0);
    idle();
    q.push_back(mk(10, 4));
    wait_valid(ok);
    e = q.pop_front();
    tests++;
    if (!ok || sum_out !== e.sum || term_count !== e.cnt) begin
      fails++;
      $display("FAIL post_reset: vld=%0b sum=%0h cnt=%0d, want %0h %0d",
               ok, sum_out, term_count, e.sum, e.cnt);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_last();
    test_backpressure();
    test_gaps();
    test_midreset();
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
